// File: rtl/sha3_squeeze.sv
`default_nettype none
// ============================================================================
// Module   : sha3_squeeze
// Brief    : Captures a permuted Keccak state and streams its rate lanes as
//            64-bit words, requesting further permutations for XOF output.
// Revision : 1.0 - initial release
// ============================================================================
module sha3_squeeze #(
    parameter int RATE_LANES = 17,
    parameter int OUT_LANES  = 4,
    parameter int LANE_W     = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [25*LANE_W-1:0] STATE_IN,
    input  logic                 STATE_VALID,
    output logic                 STATE_READY,
    output logic                 PERM_REQ,
    output logic [LANE_W-1:0]    DOUT,
    output logic                 DOUT_VALID,
    input  logic                 DOUT_READY,
    output logic                 DOUT_LAST,
    output logic                 BUSY
);

    localparam int c_NUM_LANES = 25;
    localparam int c_LANE_CW   = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;
    localparam int c_TOT_CW    = $clog2(OUT_LANES + 1);

    localparam logic [c_LANE_CW-1:0] c_LANE_LAST = c_LANE_CW'(RATE_LANES - 1);
    localparam logic [c_TOT_CW-1:0]  c_TOT_LAST  = c_TOT_CW'(OUT_LANES - 1);

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_OUTPUT    = 2'd1;
    localparam logic [1:0] c_ST_WAIT_PERM = 2'd2;

    logic [1:0]              r_state;
    logic [c_LANE_CW-1:0]    r_lane_cnt;
    logic [c_TOT_CW-1:0]     r_total_cnt;
    logic [25*LANE_W-1:0]    r_lanes;
    logic                    r_state_ready;
    logic                    r_perm_req;
    logic                    r_dout_valid;
    logic                    r_dout_last;
    logic                    r_busy;

    logic [1:0]              w_state_nxt;
    logic [c_LANE_CW-1:0]    w_lane_nxt;
    logic [c_TOT_CW-1:0]     w_total_nxt;
    logic                    w_perm_nxt;
    logic                    w_capture;
    logic [LANE_W-1:0]       w_lane_arr [c_NUM_LANES];
    logic [4:0]              w_lane_idx;

    assign w_capture = STATE_VALID & r_state_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_lane_nxt  = r_lane_cnt;
        w_total_nxt = r_total_cnt;
        w_perm_nxt  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_capture) begin
                    w_state_nxt = c_ST_OUTPUT;
                    w_lane_nxt  = '0;
                    w_total_nxt = '0;
                end
            end
            c_ST_OUTPUT: begin
                if (DOUT_READY) begin
                    // Last lane wins over the rate boundary, so no stray permutation
                    if (r_total_cnt == c_TOT_LAST) begin
                        w_state_nxt = c_ST_IDLE;
                        w_lane_nxt  = '0;
                        w_total_nxt = '0;
                    end else if (r_lane_cnt == c_LANE_LAST) begin
                        w_state_nxt = c_ST_WAIT_PERM;
                        w_lane_nxt  = '0;
                        w_total_nxt = r_total_cnt + c_TOT_CW'(1);
                        w_perm_nxt  = 1'b1;
                    end else begin
                        w_lane_nxt  = r_lane_cnt + c_LANE_CW'(1);
                        w_total_nxt = r_total_cnt + c_TOT_CW'(1);
                    end
                end
            end
            c_ST_WAIT_PERM: begin
                if (w_capture) begin
                    w_state_nxt = c_ST_OUTPUT;
                    w_lane_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_lane_nxt  = '0;
                w_total_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= c_ST_IDLE;
            r_lane_cnt    <= '0;
            r_total_cnt   <= '0;
            r_lanes       <= '0;
            r_state_ready <= 1'b1;
            r_perm_req    <= 1'b0;
            r_dout_valid  <= 1'b0;
            r_dout_last   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_lane_cnt    <= w_lane_nxt;
            r_total_cnt   <= w_total_nxt;
            if (w_capture) begin
                r_lanes <= STATE_IN;
            end
            r_state_ready <= (w_state_nxt != c_ST_OUTPUT);
            r_perm_req    <= w_perm_nxt;
            r_dout_valid  <= (w_state_nxt == c_ST_OUTPUT);
            r_dout_last   <= (w_state_nxt == c_ST_OUTPUT) && (w_total_nxt == c_TOT_LAST);
            r_busy        <= (w_state_nxt != c_ST_IDLE);
        end
    end

    for (genvar g = 0; g < c_NUM_LANES; g++) begin : g_lane
        assign w_lane_arr[g] = r_lanes[g*LANE_W +: LANE_W];
    end

    assign w_lane_idx  = 5'(r_lane_cnt);
    assign DOUT        = w_lane_arr[w_lane_idx];
    assign STATE_READY = r_state_ready;
    assign PERM_REQ    = r_perm_req;
    assign DOUT_VALID  = r_dout_valid;
    assign DOUT_LAST   = r_dout_last;
    assign BUSY        = r_busy;

endmodule
`default_nettype wire
